// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer.
//   state_e                    : FSM state encoding (RUN / load-use stall)
//   REG_ZERO                   : hard-wired zero register index
//   LOAD_STALL_CYCLES_DEFAULT  : default number of load-use bubbles
package pipeline_hazard_controller_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_LSTALL = 1'b1
  } state_e;

  localparam logic [4:0]  REG_ZERO                  = 5'd0;
  localparam int unsigned LOAD_STALL_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/pipeline_hazard_controller_hazard_stall_counter.sv
// Saturating up-counter for stalled cycles.
//   clk_i   : clock
//   rst_i   : synchronous active-high clear
//   en_i    : count this cycle
//   count_o : current count, holds at all-ones
module hazard_stall_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard and stall sequencer for the pipeline.
// Detects load-use and Hi/Lo dependencies between ID and EX/X2/X3, and
// taken branches. It drives the PC / IF/ID / ID/EX write, flush and bubble
// controls. The two-state FSM holds multi-cycle load-use stalls.
//   Clk, Reset        : clock, synchronous active-high reset
//   ID_*              : source operands/usage of the instruction in ID
//   EX_*, X2_*, X3_*  : producer information from later stages
//   Branch_Taken      : branch/jump resolved taken in EX
//   PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble : pipeline controls
//   Stall_Active      : PC held this cycle
//   Stall_Cycles      : saturating count of stalled cycles
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = LOAD_STALL_CYCLES_DEFAULT,
  parameter int unsigned CNT_W             = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_UsesHiLo,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_WriteReg,
  input  logic             EX_HiLoWrite,
  input  logic             X2_HiLoWrite,
  input  logic             X3_HiLoWrite,
  input  logic             Branch_Taken,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             Stall_Active,
  output logic [CNT_W-1:0] Stall_Cycles
);

  // Remaining stall cycles after the first one, loaded on LSTALL entry.
  localparam logic [1:0] LOAD_CNT_INIT = 2'(LOAD_STALL_CYCLES - 1);
  localparam bit         MULTI_STALL   = (LOAD_STALL_CYCLES > 1);

  typedef enum logic [1:0] {
    ACT_IDLE,
    ACT_STALL,
    ACT_FLUSH
  } action_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       load_haz;
  logic       hilo_haz;
  action_e    action;

  assign load_haz = EX_MemRead & EX_RegWrite & (EX_WriteReg != REG_ZERO) &
                    ((ID_UsesRs & (ID_Rs == EX_WriteReg)) |
                     (ID_UsesRt & (ID_Rt == EX_WriteReg)));

  // Stateless: held as long as any producer is still in EX/X2/X3.
  assign hilo_haz = ID_UsesHiLo & (EX_HiLoWrite | X2_HiLoWrite | X3_HiLoWrite);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        // A single-cycle load stall never leaves RUN.
        if (!Branch_Taken && load_haz && MULTI_STALL) begin
          cnt_d   = LOAD_CNT_INIT;
          state_d = ST_LSTALL;
        end
      end
      ST_LSTALL: begin
        if (Branch_Taken) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    action = ACT_IDLE;
    unique case (state_q)
      ST_RUN: begin
        if (Branch_Taken)               action = ACT_FLUSH;
        else if (load_haz || hilo_haz)  action = ACT_STALL;
        else                            action = ACT_IDLE;
      end
      ST_LSTALL: begin
        if (Branch_Taken) action = ACT_FLUSH;
        else              action = ACT_STALL;
      end
      default: action = ACT_IDLE;
    endcase

    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    if (Reset) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
    end else begin
      unique case (action)
        ACT_STALL: begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
        end
        ACT_FLUSH: begin
          IF_ID_Flush  = 1'b1;
          ID_EX_Bubble = 1'b1;
        end
        default: ;
      endcase
    end
    Stall_Active = ~PC_Write & ~Reset;
  end

  hazard_stall_counter #(
    .W (CNT_W)
  ) u_stall_counter (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .en_i    (Stall_Active),
    .count_o (Stall_Cycles)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  ID_Rs, ID_Rt, EX_WriteReg;
  logic        ID_UsesRs, ID_UsesRt, ID_UsesHiLo;
  logic        EX_MemRead, EX_RegWrite, EX_HiLoWrite, X2_HiLoWrite, X3_HiLoWrite;
  logic        Branch_Taken;

  logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Stall_Active;
  logic [31:0] Stall_Cycles;

  logic        PC_Write2, IF_ID_Write2, IF_ID_Flush2, ID_EX_Bubble2, Stall_Active2;
  logic [1:0]  Stall_Cycles2;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 Clk = ~Clk;

  pipeline_hazard_controller #(
    .LOAD_STALL_CYCLES (2),
    .CNT_W             (32)
  ) dut (
    .Clk (Clk), .Reset (Reset),
    .ID_Rs (ID_Rs), .ID_Rt (ID_Rt), .ID_UsesRs (ID_UsesRs), .ID_UsesRt (ID_UsesRt),
    .ID_UsesHiLo (ID_UsesHiLo), .EX_MemRead (EX_MemRead), .EX_RegWrite (EX_RegWrite),
    .EX_WriteReg (EX_WriteReg), .EX_HiLoWrite (EX_HiLoWrite), .X2_HiLoWrite (X2_HiLoWrite),
    .X3_HiLoWrite (X3_HiLoWrite), .Branch_Taken (Branch_Taken),
    .PC_Write (PC_Write), .IF_ID_Write (IF_ID_Write), .IF_ID_Flush (IF_ID_Flush),
    .ID_EX_Bubble (ID_EX_Bubble), .Stall_Active (Stall_Active), .Stall_Cycles (Stall_Cycles)
  );

  // Second instance: three-cycle load stall and a tiny counter to reach saturation.
  pipeline_hazard_controller #(
    .LOAD_STALL_CYCLES (3),
    .CNT_W             (2)
  ) dut3 (
    .Clk (Clk), .Reset (Reset),
    .ID_Rs (ID_Rs), .ID_Rt (ID_Rt), .ID_UsesRs (ID_UsesRs), .ID_UsesRt (ID_UsesRt),
    .ID_UsesHiLo (ID_UsesHiLo), .EX_MemRead (EX_MemRead), .EX_RegWrite (EX_RegWrite),
    .EX_WriteReg (EX_WriteReg), .EX_HiLoWrite (EX_HiLoWrite), .X2_HiLoWrite (X2_HiLoWrite),
    .X3_HiLoWrite (X3_HiLoWrite), .Branch_Taken (Branch_Taken),
    .PC_Write (PC_Write2), .IF_ID_Write (IF_ID_Write2), .IF_ID_Flush (IF_ID_Flush2),
    .ID_EX_Bubble (ID_EX_Bubble2), .Stall_Active (Stall_Active2), .Stall_Cycles (Stall_Cycles2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Controls of the default instance: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Stall_Active}
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Stall_Active},
          {27'd0, exp});
  endtask

  task automatic chk_ctl3(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, PC_Write2, IF_ID_Write2, IF_ID_Flush2, ID_EX_Bubble2, Stall_Active2},
          {27'd0, exp});
  endtask

  localparam logic [4:0] IDLE  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00011;
  localparam logic [4:0] FLUSH = 5'b11110;
  localparam logic [4:0] RST   = 5'b00000;

  task automatic clr_in();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; ID_UsesHiLo = 1'b0;
    EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
    EX_HiLoWrite = 1'b0; X2_HiLoWrite = 1'b0; X3_HiLoWrite = 1'b0; Branch_Taken = 1'b0;
  endtask

  // Advance one clock; new inputs are applied 1 time unit after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic lw_to(input logic [4:0] rd);
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = rd;
  endtask

  initial begin
    clr_in();
    Reset = 1'b1;
    tick();
    tick();
    settle();
    chk_ctl("reset_ctl", RST);
    check("reset_cnt", Stall_Cycles, 32'd0);

    // Inputs that would otherwise stall must be ignored while Reset is high.
    lw_to(5'd8); ID_UsesRs = 1'b1; ID_Rs = 5'd8;
    settle();
    chk_ctl("reset_masks_haz", RST);
    clr_in();

    // Load-use on rs, two bubbles.
    do_reset();
    settle();
    chk_ctl("idle_after_reset", IDLE);
    lw_to(5'd8); ID_UsesRs = 1'b1; ID_Rs = 5'd8;
    settle();
    chk_ctl("lu_stall1", STALL);
    tick();
    EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
    settle();
    chk_ctl("lu_stall2", STALL);
    check("lu_cnt_mid", Stall_Cycles, 32'd1);
    tick();
    settle();
    chk_ctl("lu_release", IDLE);
    check("lu_cnt", Stall_Cycles, 32'd2);
    tick();
    settle();
    chk_ctl("lu_stays_idle", IDLE);
    check("lu_cnt_hold", Stall_Cycles, 32'd2);

    // Load-use through rt; rs mismatch must not matter.
    do_reset();
    lw_to(5'd17); ID_UsesRs = 1'b1; ID_Rs = 5'd3; ID_UsesRt = 1'b1; ID_Rt = 5'd17;
    settle();
    chk_ctl("lu_rt", STALL);
    clr_in();
    do_reset();

    // Register match but operand not used, or EX not a load / not writing.
    lw_to(5'd9); ID_Rs = 5'd9; ID_Rt = 5'd9;
    settle();
    chk_ctl("no_use_no_stall", IDLE);
    ID_UsesRs = 1'b1; EX_MemRead = 1'b0;
    settle();
    chk_ctl("not_load_no_stall", IDLE);
    EX_MemRead = 1'b1; EX_RegWrite = 1'b0;
    settle();
    chk_ctl("no_regwrite_no_stall", IDLE);

    // Register $0 never creates a dependency.
    do_reset();
    lw_to(5'd0); ID_UsesRs = 1'b1; ID_Rs = 5'd0;
    settle();
    chk_ctl("r0_no_stall", IDLE);
    tick();
    check("r0_cnt", Stall_Cycles, 32'd0);

    // HiLo: madd walks EX -> X2 -> X3.
    do_reset();
    ID_UsesHiLo = 1'b1; EX_HiLoWrite = 1'b1;
    settle();
    chk_ctl("hilo_ex", STALL);
    tick();
    EX_HiLoWrite = 1'b0; X2_HiLoWrite = 1'b1;
    settle();
    chk_ctl("hilo_x2", STALL);
    tick();
    X2_HiLoWrite = 1'b0; X3_HiLoWrite = 1'b1;
    settle();
    chk_ctl("hilo_x3", STALL);
    tick();
    X3_HiLoWrite = 1'b0;
    settle();
    chk_ctl("hilo_release", IDLE);
    check("hilo_cnt", Stall_Cycles, 32'd3);
    ID_UsesHiLo = 1'b0; X2_HiLoWrite = 1'b1;
    settle();
    chk_ctl("hilo_not_used", IDLE);

    // Branch aborts an in-progress load stall.
    do_reset();
    lw_to(5'd8); ID_UsesRs = 1'b1; ID_Rs = 5'd8;
    settle();
    chk_ctl("abort_stall1", STALL);
    tick();
    clr_in(); Branch_Taken = 1'b1;
    settle();
    chk_ctl("abort_flush", FLUSH);
    tick();
    Branch_Taken = 1'b0;
    settle();
    chk_ctl("abort_back_run", IDLE);
    check("abort_cnt", Stall_Cycles, 32'd1);

    // Branch and load hazard together: flush only, no LSTALL entry.
    do_reset();
    lw_to(5'd8); ID_UsesRs = 1'b1; ID_Rs = 5'd8; Branch_Taken = 1'b1;
    settle();
    chk_ctl("simul_flush", FLUSH);
    tick();
    clr_in();
    settle();
    chk_ctl("simul_no_lstall", IDLE);
    check("simul_cnt", Stall_Cycles, 32'd0);

    // Reset in the middle of a load stall.
    do_reset();
    lw_to(5'd8); ID_UsesRs = 1'b1; ID_Rs = 5'd8;
    tick();
    clr_in(); Reset = 1'b1;
    settle();
    chk_ctl("rst_mid_ctl", RST);
    tick();
    settle();
    check("rst_mid_cnt", Stall_Cycles, 32'd0);
    Reset = 1'b0;
    tick();
    settle();
    chk_ctl("rst_mid_run", IDLE);
    check("rst_mid_cnt_after", Stall_Cycles, 32'd0);

    // Three-bubble instance and counter saturation.
    do_reset();
    lw_to(5'd5); ID_UsesRt = 1'b1; ID_Rt = 5'd5;
    settle();
    chk_ctl3("ls3_stall1", STALL);
    tick();
    clr_in();
    settle();
    chk_ctl3("ls3_stall2", STALL);
    chk_ctl("ls2_stall2", STALL);
    tick();
    settle();
    chk_ctl3("ls3_stall3", STALL);
    chk_ctl("ls2_released", IDLE);
    tick();
    settle();
    chk_ctl3("ls3_release", IDLE);
    check("ls3_cnt_sat", {30'd0, Stall_Cycles2}, 32'd3);
    ID_UsesHiLo = 1'b1; EX_HiLoWrite = 1'b1;
    settle();
    chk_ctl3("sat_extra_stall", STALL);
    tick();
    clr_in();
    settle();
    check("cnt_holds_sat", {30'd0, Stall_Cycles2}, 32'd3);
    check("big_cnt", Stall_Cycles, 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
